glitch_witch_sched: RTL and testbench

Run sequencer for a bank of `glitch_witch` power-stress instances. It clears their error state and ramps their enables up one instance at a time to bound di/dt, then holds full load for a programmed window. It then ramps the enables down in reverse order, waits for the error-reduction pipelines to settle, and latches a per-instance pass/fail result. It sits between the host CSR block and the stress bank.

---
 rtl/glitch_witch_sched.sv | 183 ++++++++++++++++++
 tb/tb_glitch_witch_sched.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/glitch_witch_sched.sv
// rtl/glitch_witch_sched.sv - run sequencer for a glitch_witch stress bank
// Clears the bank, ramps enables up slot by slot, holds, ramps down in reverse, settles and latches results.
module glitch_witch_sched #(
    parameter int NUM_INST      = 8,
    parameter int CLEAR_CYCLES  = 16,
    parameter int STEP_CYCLES   = 256,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                start,
    input  logic                stop,
    input  logic [31:0]         run_cycles,
    input  logic [NUM_INST-1:0] inst_mask,
    input  logic [NUM_INST-1:0] sticky_err_in,
    output logic [NUM_INST-1:0] ena,
    output logic [NUM_INST-1:0] sclr,
    output logic [NUM_INST-1:0] sclr_err,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                aborted,
    output logic [NUM_INST-1:0] err_vec,
    output logic                live_err
);
    localparam int IW = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;
    localparam logic [IW-1:0] LAST        = IW'(NUM_INST - 1);
    localparam logic [31:0]   CLEAR_LOAD  = 32'(CLEAR_CYCLES - 1);
    localparam logic [31:0]   STEP_LOAD   = 32'(STEP_CYCLES - 1);
    localparam logic [31:0]   SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RAMP_UP, S_RUN, S_RAMP_DOWN, S_SETTLE, S_CHECK
    } state_t;

    state_t              state_q;
    logic [31:0]         cnt_q;
    logic [31:0]         run_len_q;
    logic [IW-1:0]       slot_q;
    logic [NUM_INST-1:0] mask_q;
    logic [NUM_INST-1:0] ena_q;
    logic [NUM_INST-1:0] sclr_q;
    logic [NUM_INST-1:0] err_vec_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic                aborted_q;
    logic                live_err_q;

    logic                cnt_zero;
    logic [IW-1:0]       slot_nxt;
    logic [IW-1:0]       slot_prv;
    logic [NUM_INST-1:0] masked_err;
    logic                busy_d;
    logic [NUM_INST-1:0] live_mask_d;
    logic                live_err_d;

    assign cnt_zero   = (cnt_q == '0);
    assign slot_nxt   = slot_q + 1'b1;
    assign slot_prv   = slot_q - 1'b1;
    assign masked_err = sticky_err_in & mask_q;

    // live_err follows the busy/mask values that will be visible next cycle
    always_comb begin
        busy_d      = busy_q;
        live_mask_d = mask_q;
        if (state_q == S_IDLE && start) begin
            busy_d      = 1'b1;
            live_mask_d = inst_mask;
        end else if (state_q == S_SETTLE && cnt_zero) begin
            busy_d = 1'b0;
        end
    end
    assign live_err_d = busy_d & (|(sticky_err_in & live_mask_d));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            run_len_q  <= '0;
            slot_q     <= '0;
            mask_q     <= '0;
            ena_q      <= '0;
            sclr_q     <= '0;
            err_vec_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            aborted_q  <= 1'b0;
            live_err_q <= 1'b0;
        end else begin
            live_err_q <= live_err_d;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    mask_q    <= inst_mask;
                    run_len_q <= (run_cycles == '0) ? '0 : run_cycles - 32'd1;
                    aborted_q <= 1'b0;
                    pass_q    <= 1'b0;
                    err_vec_q <= '0;
                    sclr_q    <= inst_mask;
                    busy_q    <= 1'b1;
                    cnt_q     <= CLEAR_LOAD;
                    state_q   <= S_CLEAR;
                end
                S_CLEAR: if (stop) begin
                    sclr_q    <= '0;
                    aborted_q <= 1'b1;
                    cnt_q     <= SETTLE_LOAD;
                    state_q   <= S_SETTLE;
                end else if (cnt_zero) begin
                    sclr_q    <= '0;
                    slot_q    <= '0;
                    ena_q[0]  <= mask_q[0];
                    cnt_q     <= STEP_LOAD;
                    state_q   <= S_RAMP_UP;
                end else begin
                    cnt_q <= cnt_q - 32'd1;
                end
                S_RAMP_UP: if (stop) begin
                    // ramp-down begins at the slot currently being ramped
                    aborted_q     <= 1'b1;
                    ena_q[slot_q] <= 1'b0;
                    cnt_q         <= STEP_LOAD;
                    state_q       <= S_RAMP_DOWN;
                end else if (cnt_zero) begin
                    if (slot_q == LAST) begin
                        cnt_q   <= run_len_q;
                        state_q <= S_RUN;
                    end else begin
                        slot_q          <= slot_nxt;
                        ena_q[slot_nxt] <= mask_q[slot_nxt];
                        cnt_q           <= STEP_LOAD;
                    end
                end else begin
                    cnt_q <= cnt_q - 32'd1;
                end
                S_RUN: if (stop || cnt_zero) begin
                    aborted_q   <= aborted_q | stop;
                    slot_q      <= LAST;
                    ena_q[LAST] <= 1'b0;
                    cnt_q       <= STEP_LOAD;
                    state_q     <= S_RAMP_DOWN;
                end else begin
                    cnt_q <= cnt_q - 32'd1;
                end
                S_RAMP_DOWN: if (cnt_zero) begin
                    if (slot_q == '0) begin
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= S_SETTLE;
                    end else begin
                        slot_q          <= slot_prv;
                        ena_q[slot_prv] <= 1'b0;
                        cnt_q           <= STEP_LOAD;
                    end
                end else begin
                    cnt_q <= cnt_q - 32'd1;
                end
                S_SETTLE: if (cnt_zero) begin
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    err_vec_q <= masked_err;
                    pass_q    <= ~(|masked_err);
                    state_q   <= S_CHECK;
                end else begin
                    cnt_q <= cnt_q - 32'd1;
                end
                S_CHECK: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ena      = ena_q;
    assign sclr     = sclr_q;
    assign sclr_err = sclr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign aborted  = aborted_q;
    assign err_vec  = err_vec_q;
    assign live_err = live_err_q;
endmodule

// File: tb/tb_glitch_witch_sched.sv
// tb/tb_glitch_witch_sched.sv - directed and random runs against a timeline model of the sequencer
module tb_glitch_witch_sched;
    localparam int N  = 4;
    localparam int CL = 4;
    localparam int ST = 8;
    localparam int SE = 16;

    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [31:0]  run_cycles = '0;
    logic [N-1:0] inst_mask = '0;
    logic [N-1:0] sticky_err_in = '0;
    logic [N-1:0] ena, sclr, sclr_err, err_vec;
    logic         busy, done, pass, aborted, live_err;

    int total = 0;
    int bad = 0;

    glitch_witch_sched #(
        .NUM_INST(N), .CLEAR_CYCLES(CL), .STEP_CYCLES(ST), .SETTLE_CYCLES(SE)
    ) dut (
        .clk(clk), .arst(arst), .start(start), .stop(stop),
        .run_cycles(run_cycles), .inst_mask(inst_mask), .sticky_err_in(sticky_err_in),
        .ena(ena), .sclr(sclr), .sclr_err(sclr_err), .busy(busy), .done(done),
        .pass(pass), .aborted(aborted), .err_vec(err_vec), .live_err(live_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {11'd0, ena, sclr, sclr_err, busy, done, pass, aborted, err_vec, live_err};
    endfunction

    // One run from the start edge (cycle 0). Expected waveforms come from the slot timeline arithmetic.
    task automatic do_run(input logic [N-1:0] m, input int rc, input int s, input bit stop_with_start,
                          input bit err_on, input int e, input int b, input int busy_start, input int arst_at);
        int u[N];
        int d[N];
        int rce, r0, es, dc, sclr_end, si;
        bit ab;
        logic [N-1:0] ev, x_ena, x_sclr;
        logic x_live, x_busy;
        rce = (rc == 0) ? 1 : rc;
        r0 = 1 + CL + N * ST;
        sclr_end = CL;
        ab = 1'b0;
        for (int i = 0; i < N; i++) begin
            u[i] = 1 + CL + i * ST;
            d[i] = r0 + rce + (N - 1 - i) * ST;
        end
        es = r0 + rce + N * ST;
        if (s >= 1 && s <= CL) begin
            ab = 1'b1;
            sclr_end = s;
            for (int i = 0; i < N; i++) d[i] = u[i];
            es = s + 1;
        end else if (s > CL && s < r0) begin
            ab = 1'b1;
            si = (s - 1 - CL) / ST;
            for (int i = 0; i < N; i++) d[i] = (i > si) ? u[i] : s + 1 + (si - i) * ST;
            es = s + 1 + (si + 1) * ST;
        end else if (s >= r0 && s < r0 + rce) begin
            ab = 1'b1;
            for (int i = 0; i < N; i++) d[i] = s + 1 + (N - 1 - i) * ST;
            es = s + 1 + N * ST;
        end
        dc = es + SE;
        ev = (err_on && dc - 1 >= e) ? (m & (4'b0001 << b)) : '0;

        inst_mask = m;
        run_cycles = rc;
        start = 1'b1;
        stop = stop_with_start;
        sticky_err_in = '0;
        for (int c = 1; c <= dc + 1; c++) begin
            @(posedge clk);
            #1;
            x_ena = '0;
            for (int i = 0; i < N; i++)
                if (m[i] && c >= u[i] && c < d[i]) x_ena[i] = 1'b1;
            x_sclr = (c <= sclr_end) ? m : '0;
            x_busy = (c < dc);
            x_live = x_busy && err_on && m[b] && (c - 1 >= e);
            check($sformatf("cyc%0d", c),
                  {11'd0, ena, sclr, sclr_err, busy, done, pass, aborted, err_vec, live_err},
                  {11'd0, x_ena, x_sclr, x_sclr, x_busy, (c == dc), (c >= dc) && (ev == '0),
                   ab && (c > s), (c >= dc) ? ev : 4'b0000, x_live});
            if (c == dc)
                check("result", {29'd0, done, pass, aborted}, {29'd0, 1'b1, ev == '0, ab});
            if (c == arst_at) begin
                #2 arst = 1'b1;
                #1 check("arst_outs", all_outs(), 32'd0);
                arst = 1'b0;
                start = 1'b0;
                stop = 1'b0;
                sticky_err_in = '0;
                return;
            end
            start = (c == busy_start);
            stop = (c == s);
            sticky_err_in = (err_on && c >= e) ? (4'b0001 << b) : '0;
        end
        start = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check("reset_outs", all_outs(), 32'd0);
        arst = 1'b0;
        @(posedge clk);
        #1 check("idle_outs", all_outs(), 32'd0);

        do_run(4'hF, 10, 0, 1'b0, 1'b0, 0, 0, 50, 0);
        do_run(4'h5, 10, 0, 1'b0, 1'b1, 30, 2, 0, 0);
        do_run(4'h5, 10, 0, 1'b0, 1'b1, 30, 1, 0, 0);
        do_run(4'hF, 10, 15, 1'b0, 1'b0, 0, 0, 0, 0);
        do_run(4'hF, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        do_run(4'hF, 10, 0, 1'b1, 1'b0, 0, 0, 0, 0);
        do_run(4'h0, 3, 0, 1'b0, 1'b1, 10, 3, 0, 0);
        do_run(4'hF, 10, 0, 1'b0, 1'b0, 0, 0, 0, 33);
        do_run(4'hF, 10, 0, 1'b0, 1'b0, 0, 0, 0, 0);

        for (int k = 0; k < 25; k++) begin
            logic [N-1:0] rm;
            int rrc, rs, re, rb, rbs;
            bit rerr, rsws;
            rm   = 4'($urandom_range(0, 15));
            rrc  = $urandom_range(0, 12);
            rs   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 80) : 0;
            rerr = 1'($urandom_range(0, 1));
            re   = $urandom_range(1, 100);
            rb   = $urandom_range(0, N - 1);
            rsws = 1'($urandom_range(0, 1));
            rbs  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 20) : 0;
            do_run(rm, rrc, rs, rsws, rerr, re, rb, rbs, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
